// File: rtl/ram_responder_if.sv
// Strobe/address/data bundle between the control unit (master) and the RAM responder (slave).
// Keeps the original signal names so existing control-unit code maps one-to-one.
interface ram_responder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  ReadRAM;
  logic                  WriteRAM;
  logic [31:0]           Address;
  logic [DATA_WIDTH-1:0] DataIn;
  logic [DATA_WIDTH-1:0] DataOut;
  logic                  Ready;
  logic                  Busy;
  logic                  AddrErr;
  logic                  Overrun;

  modport master (
    output ReadRAM, WriteRAM, Address, DataIn,
    input  DataOut, Ready, Busy, AddrErr, Overrun
  );

  modport slave (
    input  ReadRAM, WriteRAM, Address, DataIn,
    output DataOut, Ready, Busy, AddrErr, Overrun
  );
endinterface

// File: rtl/ram_responder.sv
// Word-addressed RAM answering ReadRAM/WriteRAM strobe rising edges with a fixed latency,
// a one-cycle Ready pulse, and registered AddrErr/Overrun error pulses.
module ram_responder #(
  parameter int ADDR_WIDTH    = 9,
  parameter int DATA_WIDTH    = 32,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic            clk,
  input  logic            Reset,
  ram_responder_if.slave  bus
);

  localparam int CW    = 4;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    op_wr_q, op_wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                    rd_q, wr_q;
  logic                    addr_err_q, addr_err_d;
  logic                    overrun_q, overrun_d;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic rd_rise, wr_rise, any_rise, both_rise, addr_oor;
  logic accept, mem_we;

  assign rd_rise   = bus.ReadRAM  & ~rd_q;
  assign wr_rise   = bus.WriteRAM & ~wr_q;
  assign any_rise  = rd_rise | wr_rise;
  assign both_rise = rd_rise & wr_rise;
  assign addr_oor  = |bus.Address[31:ADDR_WIDTH];
  assign accept    = (state_q == IDLE) && (rd_rise ^ wr_rise) && !addr_oor;

  // State register and all datapath flops; RAM itself is deliberately not reset.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_wr_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      dout_q     <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_err_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_wr_q    <= op_wr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      dout_q     <= dout_d;
      rd_q       <= bus.ReadRAM;
      wr_q       <= bus.WriteRAM;
      addr_err_q <= addr_err_d;
      overrun_q  <= overrun_d;
    end
  end

  // mem_we is only ever high in BUSY, which async reset clears before any edge can commit.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q] <= data_q;
    end
  end

  // Next-state and latency counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BUSY;
          cnt_d   = wr_rise ? CW'(WRITE_LATENCY - 1) : CW'(READ_LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs, request capture, RAM access and error pulses.
  always_comb begin
    op_wr_d    = op_wr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    dout_d     = dout_q;
    addr_err_d = 1'b0;
    overrun_d  = 1'b0;
    mem_we     = 1'b0;

    if (state_q == IDLE) begin
      if (both_rise) begin
        overrun_d = 1'b1;
      end else if (any_rise && addr_oor) begin
        addr_err_d = 1'b1;
      end
    end else begin
      overrun_d = any_rise;
    end

    if (accept) begin
      op_wr_d = wr_rise;
      addr_d  = bus.Address[ADDR_WIDTH-1:0];
      data_d  = bus.DataIn;
    end

    if (state_q == BUSY && cnt_q == '0) begin
      if (op_wr_q) begin
        mem_we = 1'b1;
      end else begin
        dout_d = mem[addr_q];
      end
    end

    bus.DataOut = dout_q;
    bus.Ready   = (state_q == DONE);
    bus.Busy    = (state_q != IDLE);
    bus.AddrErr = addr_err_q;
    bus.Overrun = overrun_q;
  end

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: reference RAM model plus a read-data scoreboard queue.
module tb_ram_responder;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int RL = 2;
  localparam int WL = 1;

  logic clk = 1'b0;
  logic Reset;

  always #5 clk = ~clk;

  ram_responder_if #(.DATA_WIDTH(DW)) bus ();

  ram_responder #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .READ_LATENCY (RL),
    .WRITE_LATENCY(WL)
  ) dut (
    .clk  (clk),
    .Reset(Reset),
    .bus  (bus)
  );

  int unsigned   n_pass  = 0;
  int unsigned   n_total = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model [2**AW];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [35:0] outs();
    return {bus.DataOut, bus.Ready, bus.Busy, bus.AddrErr, bus.Overrun};
  endfunction

  task automatic wait_ready(input string tag, input int unsigned budget, output int unsigned cyc);
    cyc = 0;
    for (int unsigned i = 1; i <= budget; i++) begin
      tick();
      if (bus.Ready === 1'b1) begin
        cyc = i;
        return;
      end
    end
    check({tag, "_timeout"}, bus.Ready, 1);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [DW-1:0] data);
    int unsigned cyc;
    bus.Address  = addr;
    bus.DataIn   = data;
    bus.WriteRAM = 1'b1;
    wait_ready("wr_ready", 8, cyc);
    check("wr_latency", cyc, WL + 1);
    model[addr[AW-1:0]] = data;
    tick();
    check("wr_done_idle", {bus.Ready, bus.Busy}, 2'b00);
    bus.WriteRAM = 1'b0;
    tick();
  endtask

  task automatic do_read(input logic [31:0] addr);
    int unsigned cyc;
    exp_q.push_back(model[addr[AW-1:0]]);
    bus.Address = addr;
    bus.ReadRAM = 1'b1;
    wait_ready("rd_ready", 8, cyc);
    check("rd_latency", cyc, RL + 1);
    check("rd_data", bus.DataOut, exp_q.pop_front());
    tick();
    check("rd_done_idle", {bus.Ready, bus.Busy}, 2'b00);
    bus.ReadRAM = 1'b0;
    tick();
  endtask

  initial begin
    int unsigned cyc;
    Reset        = 1'b0;
    bus.ReadRAM  = 1'b0;
    bus.WriteRAM = 1'b0;
    bus.Address  = '0;
    bus.DataIn   = '0;
    repeat (2) tick();
    check("reset_outs", outs(), '0);
    Reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_outs", outs(), '0);
    end

    // Write 0x55, strobe held 4 cycles
    bus.Address  = 32'h0000_0055;
    bus.DataIn   = 32'hDEAD_BEEF;
    bus.WriteRAM = 1'b1;
    tick();
    check("w55_accept", {bus.Ready, bus.Busy}, 2'b01);
    tick();
    check("w55_ready", {bus.Ready, bus.Busy}, 2'b11);
    tick();
    check("w55_done", {bus.Ready, bus.Busy}, 2'b00);
    tick();
    check("w55_no_repeat", {bus.Ready, bus.Busy, bus.DataOut}, {2'b00, 32'h0});
    bus.WriteRAM = 1'b0;
    model[9'h055] = 32'hDEAD_BEEF;
    tick();

    // Read 0x55, strobe held 5 cycles
    exp_q.push_back(model[9'h055]);
    bus.ReadRAM = 1'b1;
    wait_ready("r55_ready", 8, cyc);
    check("r55_latency", cyc, RL + 1);
    check("r55_data", bus.DataOut, exp_q.pop_front());
    for (int i = 0; i < 2; i++) begin
      tick();
      check("r55_hold", {bus.Ready, bus.Busy, bus.DataOut}, {2'b00, 32'hDEAD_BEEF});
    end
    bus.ReadRAM = 1'b0;
    tick();

    // Out-of-range address
    bus.Address = 32'h0000_0200;
    bus.ReadRAM = 1'b1;
    tick();
    check("aerr_pulse", outs(), {32'hDEAD_BEEF, 4'b0010});
    tick();
    check("aerr_clear", outs(), {32'hDEAD_BEEF, 4'b0000});
    bus.ReadRAM = 1'b0;
    tick();

    // Both strobes rise together
    bus.Address  = 32'h0000_0055;
    bus.DataIn   = 32'h0BAD_0BAD;
    bus.ReadRAM  = 1'b1;
    bus.WriteRAM = 1'b1;
    tick();
    check("both_pulse", {bus.Ready, bus.Busy, bus.AddrErr, bus.Overrun}, 4'b0001);
    tick();
    check("both_clear", {bus.Ready, bus.Busy, bus.AddrErr, bus.Overrun}, 4'b0000);
    bus.ReadRAM  = 1'b0;
    bus.WriteRAM = 1'b0;
    tick();
    do_read(32'h0000_0055);

    // Read strobe while a write is in flight; address/data change after accept
    bus.Address  = 32'h0000_0010;
    bus.DataIn   = 32'h0000_1234;
    bus.WriteRAM = 1'b1;
    tick();
    check("ovr_accept", {bus.Busy, bus.Overrun}, 2'b10);
    bus.ReadRAM = 1'b1;
    bus.Address = 32'h0000_0011;
    bus.DataIn  = 32'hFFFF_FFFF;
    tick();
    check("ovr_pulse", {bus.Ready, bus.Busy, bus.Overrun}, 3'b111);
    tick();
    check("ovr_clear", {bus.Ready, bus.Busy, bus.Overrun}, 3'b000);
    model[9'h010] = 32'h0000_1234;
    bus.ReadRAM  = 1'b0;
    bus.WriteRAM = 1'b0;
    tick();
    do_read(32'h0000_0010);

    // Top in-range address
    do_write(32'h0000_01FF, 32'hCAFE_F00D);
    do_read(32'h0000_01FF);

    // Reset during an in-flight write
    do_write(32'h0000_0020, 32'h0000_AAAA);
    bus.Address  = 32'h0000_0020;
    bus.DataIn   = 32'h0000_5555;
    bus.WriteRAM = 1'b1;
    tick();
    check("rst_mid_busy", bus.Busy, 1'b1);
    Reset = 1'b0;
    #1;
    check("rst_mid_outs", outs(), '0);
    bus.WriteRAM = 1'b0;
    tick();
    check("rst_hold_outs", outs(), '0);
    Reset = 1'b1;
    tick();
    do_read(32'h0000_0020);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Memory-side responder to the control unit's ReadRAM/WriteRAM strobes.
- Takes the word address from MAR and write data from MDR, and holds a word-addressed 32-bit RAM.
- Performs each access with a fixed, parameterised latency and pulses Ready when done; read data is presented to the MDR input mux.
- One access per strobe rising edge, so strobes the control unit holds for several cycles do not cause repeated accesses.

Parameters:
ADDR_WIDTH, 9, word-address bits; RAM depth 2**ADDR_WIDTH (512 words).
DATA_WIDTH, 32, word width.
READ_LATENCY, 2, clock edges from accept to read completion; legal values 1..15.
WRITE_LATENCY, 1, clock edges from accept to write commit; legal values 1..15.

Ports:
clk  input  1  system clock; all state changes on rising edge.
Reset  input  1  asynchronous, active-low reset (0 = reset).
ReadRAM  input  1  read strobe from control unit (level; request on rising edge).
WriteRAM  input  1  write strobe from control unit (level; request on rising edge).
Address  input  32  from MAR; low ADDR_WIDTH bits index RAM.
DataIn  input  DATA_WIDTH  write data from MDR.
DataOut  output  DATA_WIDTH  last completed read data; held until the next read completes.
Ready  output  1  one-cycle pulse on access completion (read or write).
Busy  output  1  high while an access is in flight (states BUSY and DONE).
AddrErr  output  1  one-cycle pulse: access rejected because Address[31:ADDR_WIDTH] != 0.
Overrun  output  1  one-cycle pulse: strobe rising edge arrived while not IDLE, or both strobes rose together.

Behaviour:
- Reset (Reset=0, async):
  - State IDLE, counter 0.
  - DataOut=0, Ready=0, Busy=0, AddrErr=0, Overrun=0.
  - Strobe history registers rd_q=0 and wr_q=0.
  - RAM contents are not cleared and persist across reset.
- Edge detect: rd_q<=ReadRAM and wr_q<=WriteRAM every edge. rd_rise = ReadRAM & ~rd_q; wr_rise = WriteRAM & ~wr_q.
- A strobe already high when reset releases counts as a rising edge on the first edge after release.
- States: IDLE, BUSY, DONE.
- IDLE:
  - rd_rise XOR wr_rise with an in-range address:
    - Latch op, Address[ADDR_WIDTH-1:0] and DataIn.
    - Load cnt = LAT-1 (LAT is READ_LATENCY or WRITE_LATENCY).
    - Go to BUSY; Busy=1.
  - rd_rise XOR wr_rise with an out-of-range address: stay IDLE, AddrErr pulses 1 cycle, no access, no Ready.
  - rd_rise AND wr_rise together: stay IDLE, Overrun pulses 1 cycle, no access.
- BUSY:
  - cnt != 0: cnt <= cnt-1.
  - cnt == 0, read: DataOut <= RAM[addr], Ready <= 1, go to DONE.
  - cnt == 0, write: RAM[addr] <= latched data, Ready <= 1, go to DONE.
- DONE: Ready <= 0, Busy <= 0, go to IDLE. Total occupancy LAT+1 cycles.
- Timing: with the accept edge at k, Ready is high from edge k+LAT to edge k+LAT+1. The earliest next accept is edge k+LAT+1.
- Any strobe rising edge seen in BUSY or DONE is dropped, Overrun pulses 1 cycle, and the in-flight access is unaffected.
- Address and DataIn changes after the accept edge are ignored because values are latched.
- Write does not modify DataOut.
- A read accepted after a write's Ready returns the new data. No bypass is needed because accesses are serialised.
- Reset mid-BUSY aborts the access: an uncommitted write is not performed, outputs return to reset values, and state returns to IDLE.
- Error pulses (AddrErr, Overrun) are registered, asserted for exactly one cycle, and mutually independent of Ready.

Test Plan:
- Reset=0 then 1, no strobes -> DataOut=0, Ready=0, Busy=0, AddrErr=0, Overrun=0 for 5 cycles.
- WriteRAM rises at edge k with Address=0x0000_0055, DataIn=0xDEADBEEF, held 4 cycles -> Ready pulses exactly once, high between edges k+1 and k+2; Busy high for 2 cycles.
- ReadRAM rises with Address=0x55, held 5 cycles -> Ready high between edges k+2 and k+3, DataOut=0xDEADBEEF. Holding ReadRAM produces no second access, and DataOut is held thereafter.
- ReadRAM rises with Address=0x0000_0200 -> AddrErr pulses 1 cycle, Ready stays 0, Busy stays 0, DataOut unchanged.
- ReadRAM and WriteRAM rise on the same edge -> Overrun pulses 1 cycle, no RAM change (a later read of that address returns the old value).
- WriteRAM to 0x10 with 0x1234 accepted, ReadRAM rises 1 cycle later -> Overrun pulses, the write still completes with one Ready pulse, and a later read of 0x10 returns 0x1234.
- Reset=0 asserted mid-write to 0x20 (RAM[0x20]=0xAAAA beforehand) -> a subsequent read of 0x20 returns 0xAAAA, and all outputs are 0 during reset.
